// File: rtl/fetch_pkg.sv
// Shared widths and the buffered fetch entry type for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_D = 12;
    localparam int FETCH_W = 9;

    typedef struct packed {
        logic [FETCH_W-1:0] instr;
        logic [FETCH_D-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of fetched instructions tagged with their addresses.
// Head entry is presented directly from storage; flush empties it in one edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int OW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  fetch_entry_t    push_entry,
    input  logic            pop,
    input  logic            flush,
    output logic [OW-1:0]   occ,
    output fetch_entry_t    head,
    output logic            head_valid
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pop_ok;

    assign pop_ok     = pop && (occ != '0);
    assign head       = mem[rd_ptr];
    assign head_valid = (occ != '0);

    // Storage, pointers and occupancy; flush discards everything, push and pop may coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ <= occ + OW'(push) - OW'(pop_ok);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one memory read per cycle when the FIFO can
// absorb the returning word, tags returns with their address, and drops
// anything outstanding or buffered when a jump redirects the PC.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int D     = FETCH_D,
    parameter int W     = FETCH_W,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [D-1:0] pc,
    input  logic         jump_taken,
    output logic         pc_hold,
    output logic [D-1:0] imem_addr,
    output logic         imem_rd,
    input  logic [W-1:0] imem_rdata,
    output logic [W-1:0] instr,
    output logic [D-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready
);

    localparam int OW = $clog2(DEPTH + 1);

    logic          inflight;
    logic [D-1:0]  inflight_pc;
    logic          issue;
    logic          pop;
    logic          fifo_push;
    logic [OW-1:0] fifo_occ;
    logic [OW:0]   level;
    logic [OW:0]   limit;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign pop        = instr_valid && instr_ready;
    assign fifo_push  = inflight && !jump_taken;
    assign push_entry = '{instr: imem_rdata, pc: inflight_pc};

    assign imem_addr  = pc;
    assign imem_rd    = issue;
    assign pc_hold    = !issue;

    assign instr      = head.instr;
    assign instr_pc   = head.pc;

    // Issue only when the word coming back next cycle is guaranteed a FIFO slot.
    always_comb begin
        level = {1'b0, fifo_occ} + (OW+1)'(inflight);
        limit = (OW+1)'(DEPTH) + (OW+1)'(pop);
        issue = reset && !jump_taken && (level < limit);
    end

    // Remember that a read is outstanding and which address it was for.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (jump_taken),
        .occ        (fifo_occ),
        .head       (head),
        .head_valid (instr_valid)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomised-ready bench for instr_fetch with a reference queue scoreboard.
module tb_instr_fetch;

    localparam int D     = 12;
    localparam int W     = 9;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [D-1:0] pc = '0;
    logic         jump_taken = 1'b0;
    logic         pc_hold;
    logic [D-1:0] imem_addr;
    logic         imem_rd;
    logic [W-1:0] imem_rdata = '0;
    logic [W-1:0] instr;
    logic [D-1:0] instr_pc;
    logic         instr_valid;
    logic         instr_ready = 1'b0;

    logic [D-1:0] jump_target = '0;
    logic [D-1:0] ref_q[$];
    logic         model_inflight = 1'b0;
    logic [D-1:0] model_inflight_pc = '0;
    int           read_count = 0;
    int           delivered[int];
    int           n_checks = 0;
    int           n_fail = 0;

    instr_fetch #(
        .D           (D),
        .W           (W),
        .DEPTH       (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .jump_taken  (jump_taken),
        .pc_hold     (pc_hold),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] exp_instr(input logic [D-1:0] a);
        return 9'h1A0 + a[8:0];
    endfunction

    function automatic int times_delivered(input int a);
        return delivered.exists(a) ? delivered[a] : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic jmp, input logic [D-1:0] tgt);
        instr_ready = rdy;
        jump_taken  = jmp;
        jump_target = tgt;
        #2;
    endtask

    // One clock: scoreboard the pre-edge state, then update memory and PC models.
    task automatic tick();
        logic         rd_s;
        logic         hold_s;
        logic         jmp_s;
        logic [D-1:0] addr_s;
        rd_s   = imem_rd;
        hold_s = pc_hold;
        jmp_s  = jump_taken;
        addr_s = imem_addr;
        if (!reset) begin
            ref_q.delete();
            model_inflight = 1'b0;
        end else begin
            checkOutput("valid_vs_ref", 32'(instr_valid), 32'(ref_q.size() != 0));
            checkOutput("occ_vs_ref", 32'(dut.fifo_occ), 32'(ref_q.size()));
            if (ref_q.size() != 0) begin
                checkOutput("head_pc", 32'(instr_pc), 32'(ref_q[0]));
                checkOutput("head_instr", 32'(instr), 32'(exp_instr(ref_q[0])));
            end
            if (dut.fifo_push) begin
                checkOutput("push_room", 32'(int'(dut.fifo_occ) < DEPTH), 32'd1);
            end
            if (instr_valid && instr_ready) begin
                delivered[int'(instr_pc)] = times_delivered(int'(instr_pc)) + 1;
                if (ref_q.size() != 0) begin
                    void'(ref_q.pop_front());
                end
            end
            if (jmp_s) begin
                ref_q.delete();
            end else if (model_inflight) begin
                ref_q.push_back(model_inflight_pc);
            end
            model_inflight    = rd_s;
            model_inflight_pc = addr_s;
            if (rd_s) begin
                read_count++;
            end
        end
        @(posedge clk);
        #1;
        imem_rdata = rd_s ? exp_instr(addr_s) : 9'h155;
        if (!reset) begin
            pc = '0;
        end else if (jmp_s) begin
            pc = jump_target;
        end else if (!hold_s) begin
            pc = pc + 1'b1;
        end
    endtask

    initial begin
        // Reset values and first fetches after release.
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr", 32'(instr), 32'd0);
        checkOutput("rst_instr_pc", 32'(instr_pc), 32'd0);
        checkOutput("rst_imem_rd", 32'(imem_rd), 32'd0);
        checkOutput("rst_pc_hold", 32'(pc_hold), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("rel_imem_rd", 32'(imem_rd), 32'd1);
        checkOutput("rel_pc_hold", 32'(pc_hold), 32'd0);
        checkOutput("rel_addr", 32'(imem_addr), 32'h000);
        checkOutput("rel_valid0", 32'(instr_valid), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("rel_valid1", 32'(instr_valid), 32'd0);
        checkOutput("rel_addr1", 32'(imem_addr), 32'h001);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("first_valid", 32'(instr_valid), 32'd1);
        checkOutput("first_pc", 32'(instr_pc), 32'h000);
        checkOutput("first_instr", 32'(instr), 32'h1A0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("stream_valid", 32'(instr_valid), 32'd1);
            checkOutput("stream_pc", 32'(instr_pc), 32'(i));
            tick();
        end

        // Decoder stalled from reset: two reads fill the FIFO, then hold.
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);
        tick();
        reset = 1'b1;
        read_count = 0;
        delivered.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("stall_reads", 32'(read_count), 32'd2);
        checkOutput("stall_hold", 32'(pc_hold), 32'd1);
        checkOutput("stall_rd", 32'(imem_rd), 32'd0);
        checkOutput("stall_occ", 32'(dut.fifo_occ), 32'd2);
        checkOutput("stall_head", 32'(instr_pc), 32'h000);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("resume_pc0", 32'(instr_pc), 32'h000);
        checkOutput("resume_rd", 32'(imem_rd), 32'd1);
        checkOutput("resume_addr", 32'(imem_addr), 32'h002);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("resume_pc1", 32'(instr_pc), 32'h001);
        checkOutput("resume_valid1", 32'(instr_valid), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("resume_pc2", 32'(instr_pc), 32'h002);
        checkOutput("resume_valid2", 32'(instr_valid), 32'd1);
        tick();
        checkOutput("resume_once0", 32'(times_delivered(0)), 32'd1);
        checkOutput("resume_once1", 32'(times_delivered(1)), 32'd1);

        // Jump with 0x005 in flight and 0x004 buffered, target 0x0C3.
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, '0);
        tick();
        reset = 1'b1;
        delivered.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, '0);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 12'h0C3);
        checkOutput("jmp_head", 32'(instr_pc), 32'h004);
        checkOutput("jmp_inflight_pc", 32'(dut.inflight_pc), 32'h005);
        checkOutput("jmp_rd", 32'(imem_rd), 32'd0);
        checkOutput("jmp_hold", 32'(pc_hold), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("jmp1_valid", 32'(instr_valid), 32'd0);
        checkOutput("jmp1_occ", 32'(dut.fifo_occ), 32'd0);
        checkOutput("jmp1_rd", 32'(imem_rd), 32'd1);
        checkOutput("jmp1_addr", 32'(imem_addr), 32'h0C3);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("jmp2_valid", 32'(instr_valid), 32'd0);
        checkOutput("jmp2_addr", 32'(imem_addr), 32'h0C4);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("jmp3_valid", 32'(instr_valid), 32'd1);
        checkOutput("jmp3_pc", 32'(instr_pc), 32'h0C3);
        checkOutput("jmp3_instr", 32'(instr), 32'h063);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("jmp4_pc", 32'(instr_pc), 32'h0C4);
        tick();

        // Jump in the same cycle as a pop of 0x0C5; 0x0C6 is in flight.
        applyStimulus(1'b1, 1'b1, 12'h200);
        checkOutput("jpop_valid", 32'(instr_valid), 32'd1);
        checkOutput("jpop_pc", 32'(instr_pc), 32'h0C5);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("jpop1_valid", 32'(instr_valid), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("jpop2_valid", 32'(instr_valid), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("jpop3_valid", 32'(instr_valid), 32'd1);
        checkOutput("jpop3_pc", 32'(instr_pc), 32'h200);
        checkOutput("jpop3_instr", 32'(instr), 32'h1A0);
        tick();
        checkOutput("never_004", 32'(times_delivered(12'h004)), 32'd0);
        checkOutput("never_005", 32'(times_delivered(12'h005)), 32'd0);
        checkOutput("once_0c5", 32'(times_delivered(12'h0C5)), 32'd1);
        checkOutput("never_0c6", 32'(times_delivered(12'h0C6)), 32'd0);

        // Asynchronous reset while the FIFO is full.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("full_occ", 32'(dut.fifo_occ), 32'd2);
        checkOutput("full_head", 32'(instr_pc), 32'h201);
        reset = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(instr_valid), 32'd0);
        checkOutput("arst_rd", 32'(imem_rd), 32'd0);
        checkOutput("arst_hold", 32'(pc_hold), 32'd1);
        checkOutput("arst_instr_pc", 32'(instr_pc), 32'd0);
        tick();
        reset = 1'b1;
        delivered.delete();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("restart_rd", 32'(imem_rd), 32'd1);
        checkOutput("restart_addr", 32'(imem_addr), 32'h000);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("restart_valid", 32'(instr_valid), 32'd1);
        checkOutput("restart_pc", 32'(instr_pc), 32'h000);
        tick();

        // Random decoder readiness with occasional jumps against the reference queue.
        for (int i = 0; i < 10000; i++) begin
            logic j;
            logic r;
            j = ($urandom_range(0, 49) == 0);
            r = ($urandom_range(0, 1) == 1);
            applyStimulus(r, j, 12'($urandom));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
